// File: rtl/rv_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response plus the IF/ID handoff.
// master = fetch unit side, slave = memory/decode/branch side.
interface rv_fetch_unit_if #(
   parameter int PC_W     = 9,
   parameter int INS_W    = 32,
   parameter int FQ_DEPTH = 4
);
   logic                          imem_req;
   logic [PC_W-1:0]               imem_addr;
   logic [INS_W-1:0]              imem_rdata;
   logic                          redirect_valid;
   logic [PC_W-1:0]               redirect_pc;
   logic                          id_ready;
   logic                          id_valid;
   logic [PC_W-1:0]               id_pc;
   logic [INS_W-1:0]              id_instr;
   logic [$clog2(FQ_DEPTH):0]     fq_count;

   // id_valid/id_ready: head instruction transfers on a cycle where both are 1;
   // id_valid never depends on id_ready, and a redirect overrides any transfer.
   modport master (
      output imem_req, imem_addr, id_valid, id_pc, id_instr, fq_count,
      input  imem_rdata, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_pc, id_instr, fq_count,
      output imem_rdata, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/rv_fetch_unit.sv
// RV32I fetch front end: PC generator, single outstanding fetch to a 1-cycle
// instruction memory, and an FQ_DEPTH-entry prefetch queue feeding IF/ID.
module rv_fetch_unit #(
   parameter int              PC_W     = 9,
   parameter int              INS_W    = 32,
   parameter int              FQ_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   rv_fetch_unit_if.master bus
);
   localparam int PTR_W = $clog2(FQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PC_W-1:0]  r_fpc;
   logic [PC_W-1:0]  r_inflight_pc;
   logic             r_inflight;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PC_W-1:0]  r_q_pc    [FQ_DEPTH];
   logic [INS_W-1:0] r_q_instr [FQ_DEPTH];

   logic [CNT_W:0]   w_occupancy;
   logic             w_issue;
   logic             w_push;
   logic             w_pop;
   logic             w_valid;

   // Occupancy counts the in-flight fetch so a returning word always has a slot;
   // a same-cycle pop is deliberately not credited.
   assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
   assign w_issue     = !reset && !bus.redirect_valid &&
                        (w_occupancy < (CNT_W+1)'(FQ_DEPTH));
   assign w_push      = r_inflight && !bus.redirect_valid;
   assign w_valid     = (r_count != '0);
   assign w_pop       = w_valid && bus.id_ready && !bus.redirect_valid;

   assign bus.imem_req  = w_issue;
   assign bus.imem_addr = r_fpc;
   assign bus.id_valid  = w_valid;
   assign bus.id_pc     = w_valid ? r_q_pc[r_rd_ptr]    : '0;
   assign bus.id_instr  = w_valid ? r_q_instr[r_rd_ptr] : '0;
   assign bus.fq_count  = r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fpc         <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
      end else if (bus.redirect_valid) begin
         r_fpc      <= {bus.redirect_pc[PC_W-1:2], 2'b00};
         r_inflight <= 1'b0;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else begin
         if (w_issue) begin
            r_fpc         <= r_fpc + PC_W'(4);
            r_inflight_pc <= r_fpc;
         end
         r_inflight <= w_issue;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   // Queue storage carries no reset; entries are only visible through r_count.
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_q_pc[r_wr_ptr]    <= r_inflight_pc;
         r_q_instr[r_wr_ptr] <= bus.imem_rdata;
      end
   end

   always @(posedge clk) begin
      if (!reset && w_push) begin
         a_no_push_when_full: assert (r_count < CNT_W'(FQ_DEPTH));
      end
   end
endmodule
